// File: rtl/user_input_conditioner.sv
// Conditions a raw switch/key input: synchronizer chain, debounce FSM, and press counting.
// Emits a registered one-cycle pulse per accepted press and a debounced level.
module user_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_in,
  input  logic                 i_clr,
  output logic                 o_pulse,
  output logic                 o_level,
  output logic [CNT_WIDTH-1:0] o_press_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEB_HIGH = 2'd1,
    HELD     = 2'd2,
    DEB_LOW  = 2'd3
  } state_t;

  localparam logic [7:0] LP_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  logic [7:0]             r_cnt;
  logic                   r_pulse;
  logic                   r_level;
  logic [CNT_WIDTH-1:0]   r_press_count;

  logic w_s;
  logic w_accept;

  // Only the last synchronizer stage is allowed to reach the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
    end
  end

  assign w_s      = r_sync[SYNC_STAGES-1];
  assign w_accept = (r_state == DEB_HIGH) && w_s && (r_cnt == LP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_pulse <= 1'b0;
      r_level <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_s) begin
            r_state <= DEB_HIGH;
            r_cnt   <= 8'd1;
          end
        end
        DEB_HIGH: begin
          if (!w_s) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
          end else if (w_accept) begin
            r_state <= HELD;
            r_cnt   <= 8'd0;
            r_pulse <= 1'b1;
            r_level <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        HELD: begin
          if (!w_s) begin
            r_state <= DEB_LOW;
            r_cnt   <= 8'd1;
          end
        end
        DEB_LOW: begin
          if (w_s) begin
            r_state <= HELD;
            r_cnt   <= 8'd0;
          end else if (r_cnt == LP_LAST) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_level <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= 8'd0;
          r_level <= 1'b0;
        end
      endcase
    end
  end

  // Clear takes priority over a press landing on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_press_count <= '0;
    end else if (i_clr) begin
      r_press_count <= '0;
    end else if (w_accept) begin
      r_press_count <= r_press_count + CNT_WIDTH'(1);
    end
  end

  assign o_pulse       = r_pulse;
  assign o_level       = r_level;
  assign o_press_count = r_press_count;

endmodule

// File: tb/tb_user_input_conditioner.sv
// Directed bench for user_input_conditioner: two instances (8-bit and 2-bit press counters)
// share one stimulus stream; outputs are sampled on the falling clock edge.
module tb_user_input_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_raw;
  logic       clr;
  logic       p8, l8, p2, l2;
  logic [7:0] c8;
  logic [1:0] c2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  user_input_conditioner dut8 (
    .clk(clk), .rst_n(rst_n), .i_in(in_raw), .i_clr(clr),
    .o_pulse(p8), .o_level(l8), .o_press_count(c8)
  );

  user_input_conditioner #(.CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .i_in(in_raw), .i_clr(clr),
    .o_pulse(p2), .o_level(l2), .o_press_count(c2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive in for n cycles and check how many pulses each instance emits.
  task automatic phase(input logic v, input int n, input int exp_pulses, input string tag);
    int np8;
    int np2;
    np8 = 0;
    np2 = 0;
    in_raw = v;
    repeat (n) begin
      @(negedge clk);
      if (p8 === 1'b1) np8++;
      if (p2 === 1'b1) np2++;
    end
    chk({tag, "_pulses8"}, np8, exp_pulses);
    chk({tag, "_pulses2"}, np2, exp_pulses);
  endtask

  initial begin
    rst_n  = 1'b0;
    in_raw = 1'b0;
    clr    = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pulse", p8, 0);
    chk("rst_level", l8, 0);
    chk("rst_count8", c8, 0);
    chk("rst_count2", c2, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    $display("reset: outputs idle");

    // Single press: in first sampled at edge 1, pulse after edge 6.
    in_raw = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk("t1_pulse8", p8, (k == 6));
      chk("t1_pulse2", p2, (k == 6));
      chk("t1_level", l8, (k >= 6));
    end
    chk("t1_count8", c8, 1);
    chk("t1_count2", c2, 1);
    phase(1'b0, 12, 0, "t1_release");
    chk("t1_level_low", l8, 0);
    $display("press: pulse at edge 6, count=%0d", c8);

    // Glitch of 3 cycles must be rejected.
    in_raw = 1'b1;
    repeat (3) @(negedge clk);
    in_raw = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("t2_pulse", p8, 0);
      chk("t2_level", l8, 0);
    end
    chk("t2_count8", c8, 1);
    $display("glitch: rejected, count=%0d", c8);

    // Short release dropout while held must not re-trigger.
    phase(1'b1, 10, 1, "t3_press");
    chk("t3_level_high", l8, 1);
    in_raw = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("t3_dropout_level", l8, 1);
    end
    in_raw = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t3_pulse", p8, 0);
      chk("t3_level", l8, 1);
    end
    chk("t3_count8", c8, 2);
    phase(1'b0, 12, 0, "t3_release");
    chk("t3_level_low", l8, 0);
    $display("dropout: no second press, count=%0d", c8);

    // Clear, then five presses: 2-bit counter wraps to 1.
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("t4_clr8", c8, 0);
    chk("t4_clr2", c2, 0);
    for (int i = 0; i < 5; i++) begin
      phase(1'b1, 10, 1, "t4_press");
      phase(1'b0, 10, 0, "t4_release");
    end
    chk("t4_count8", c8, 5);
    chk("t4_count2_wrap", c2, 1);
    $display("five presses: count8=%0d count2=%0d", c8, c2);

    // Clear landing on the pulse edge wins over the press.
    for (int i = 0; i < 2; i++) begin
      phase(1'b1, 10, 1, "t5_press");
      phase(1'b0, 10, 0, "t5_release");
    end
    chk("t5_pre_count2", c2, 3);
    chk("t5_pre_count8", c8, 7);
    in_raw = 1'b1;
    repeat (5) @(negedge clk);
    chk("t5_pre_pulse", p8, 0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("t5_pulse8", p8, 1);
    chk("t5_pulse2", p2, 1);
    chk("t5_count8", c8, 0);
    chk("t5_count2", c2, 0);
    @(negedge clk);
    chk("t5_pulse_once", p8, 0);
    chk("t5_count8_hold", c8, 0);
    phase(1'b0, 10, 0, "t5_release");
    phase(1'b1, 10, 1, "t5_repress");
    chk("t5_count8_after", c8, 1);
    phase(1'b0, 10, 0, "t5_release2");
    $display("clr on pulse edge: count cleared");

    // Asynchronous reset mid-qualification, then full requalification with in held high.
    in_raw = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_pulse", p8, 0);
    chk("t6_async_level", l8, 0);
    chk("t6_async_count8", c8, 0);
    chk("t6_async_count2", c2, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("t6_pulse", p8, (k == 6));
      chk("t6_level", l8, (k >= 6));
    end
    chk("t6_count8", c8, 1);
    chk("t6_count2", c2, 1);
    in_raw = 1'b0;
    repeat (10) @(negedge clk);
    $display("async reset: requalified, count=%0d", c8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
